normalise_adder_pipe: RTL and testbench

Parametrised, back-pressured successor to the post-add normalisation stage of the HCORDIC floating-point adder. It takes the raw extended sum and the packed result word from the add stage. It renormalises the sum with a leading-zero count, adjusts the exponent, and optionally flags or handles exponent overflow and underflow. It sits between the adder's add stage and its pack/round stage, and passes the CORDIC sideband (z, opcode, instruction tag, idle) through in lockstep.

---
 rtl/normalise_pkg.sv | 36 +++
 rtl/normalise_adder_pipe_lzc.sv | 18 +
 rtl/normalise_adder_pipe.sv | 165 ++++++++++++++++
 tb/tb_normalise_adder_pipe.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/normalise_pkg.sv
// Shared widths, CORDIC opcode codes and width helpers for the post-add normalisation pipe.
package normalise_pkg;

  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam int GRD_W_DEF = 3;
  localparam int Z_W_DEF   = 32;
  localparam int OPC_W_DEF = 4;
  localparam int TAG_W_DEF = 8;

  localparam int sin_cos    = 0;
  localparam int sinh_cosh  = 1;
  localparam int arctan     = 2;
  localparam int arctanh    = 3;
  localparam int exp        = 4;
  localparam int sqr_root   = 5;
  localparam int division   = 6;
  localparam int tan        = 7;
  localparam int tanh       = 8;
  localparam int nat_log    = 9;
  localparam int hypotenuse = 10;
  localparam int PreProcess = 11;

  // Extended sum: carry-out, hidden bit, fraction, guard/round/sticky.
  function automatic int sum_width(input int man_w, input int grd_w);
    return man_w + grd_w + 2;
  endfunction

  // Count range is 0..man_w+1 inclusive.
  function automatic int lz_width(input int man_w);
    return $clog2(man_w + 2);
  endfunction

  localparam int SUM_W_DEF = sum_width(MAN_W_DEF, GRD_W_DEF);

endpackage

// File: rtl/normalise_adder_pipe_lzc.sv
// Leading-zero counter, purely combinational; returns W for an all-zero input.
module lzc_priority #(
  parameter int W  = 24,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  data,
  output logic [CW-1:0] count
);

  // Later (higher) set bits override, so the MSB-most one decides the count.
  always_comb begin
    count = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (data[i]) count = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/normalise_adder_pipe.sv
// Post-add normalisation: 2-cycle latency, 1 beat/cycle, elastic 2-entry valid/ready pipe.
// NORMALISE_EXC_EN enables exponent overflow/underflow handling; otherwise exponent wraps.
module normalise_adder_pipe
  import normalise_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF,
  parameter int GRD_W = GRD_W_DEF,
  parameter int Z_W   = Z_W_DEF,
  parameter int OPC_W = OPC_W_DEF,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_idle,
  input  logic [EXP_W+MAN_W:0]     in_sout,
  input  logic [MAN_W+GRD_W+1:0]   in_sum,
  input  logic [Z_W-1:0]           in_z,
  input  logic [OPC_W-1:0]         in_opcode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_idle,
  output logic [EXP_W+MAN_W:0]     out_sout,
  output logic [MAN_W+GRD_W+1:0]   out_sum,
  output logic [Z_W-1:0]           out_z,
  output logic [OPC_W-1:0]         out_opcode,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     out_oflow,
  output logic                     out_uflow
);

  localparam int SUM_W  = sum_width(MAN_W, GRD_W);
  localparam int FLD_W  = MAN_W + 1;
  localparam int LZ_W   = lz_width(MAN_W);
  localparam int EW     = EXP_W + 2;
  localparam int SOUT_W = 1 + EXP_W + MAN_W;

  logic               s1_vld, s1_idle, s1_carry, s1_zero;
  logic [SOUT_W-1:0]  s1_sout;
  logic [SUM_W-1:0]   s1_sum;
  logic [Z_W-1:0]     s1_z;
  logic [OPC_W-1:0]   s1_opcode;
  logic [TAG_W-1:0]   s1_tag;
  logic [LZ_W-1:0]    s1_lz, lz_in;
  logic               adv;

  assign adv      = !out_valid || out_ready;
  assign in_ready = !s1_vld || adv;

  lzc_priority #(.W(FLD_W), .CW(LZ_W)) u_lzc (
    .data  (in_sum[SUM_W-2:GRD_W]),
    .count (lz_in)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_vld    <= 1'b0;
      s1_idle   <= 1'b0;
      s1_carry  <= 1'b0;
      s1_zero   <= 1'b0;
      s1_sout   <= '0;
      s1_sum    <= '0;
      s1_z      <= '0;
      s1_opcode <= '0;
      s1_tag    <= '0;
      s1_lz     <= '0;
    end else if (in_ready) begin
      s1_vld <= in_valid;
      if (in_valid) begin
        s1_idle   <= in_idle;
        s1_carry  <= in_sum[SUM_W-1];
        s1_zero   <= (in_sum[SUM_W-2:GRD_W] == '0);
        s1_sout   <= in_sout;
        s1_sum    <= in_sum;
        s1_z      <= in_z;
        s1_opcode <= in_opcode;
        s1_tag    <= in_tag;
        s1_lz     <= lz_in;
      end
    end
  end

  logic signed [EW-1:0] e_in, e_adj;
  logic [SOUT_W-1:0]    n_sout;
  logic [SUM_W-1:0]     n_sum;
  logic                 n_oflow, n_uflow;

  always_comb begin
    e_in    = {2'b00, s1_sout[MAN_W +: EXP_W]};
    e_adj   = e_in;
    n_sout  = s1_sout;
    n_sum   = s1_sum;
    n_oflow = 1'b0;
    n_uflow = 1'b0;
    if (s1_idle) begin
      n_sum = '0;
    end else if (s1_carry) begin
      e_adj = e_in + EW'(1);
      n_sum = {1'b0, s1_sum[SUM_W-1:2], s1_sum[1] | s1_sum[0]};
    end else if (s1_zero) begin
      e_adj = '0;
      n_sum = '0;
    end else begin
      e_adj = e_in - {{(EW-LZ_W){1'b0}}, s1_lz};
      n_sum = s1_sum << s1_lz;
    end
`ifdef NORMALISE_EXC_EN
    // Zero and idle beats are exact; only real arithmetic can leave the exponent range.
    if (!s1_idle && !s1_zero) begin
      n_oflow = !e_adj[EW-1] && (e_adj >= EW'((1 << EXP_W) - 1));
      n_uflow = e_adj[EW-1] || (e_adj == '0);
    end
    if (n_oflow) begin
      n_sout[MAN_W +: EXP_W] = '1;
      n_sum                  = '0;
    end else if (n_uflow) begin
      n_sout[MAN_W +: EXP_W] = '0;
      n_sum                  = '0;
    end else begin
      n_sout[MAN_W +: EXP_W] = e_adj[EXP_W-1:0];
    end
`else
    n_sout[MAN_W +: EXP_W] = e_adj[EXP_W-1:0];
`endif
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_idle   <= 1'b0;
      out_sout   <= '0;
      out_sum    <= '0;
      out_z      <= '0;
      out_opcode <= '0;
      out_tag    <= '0;
`ifdef NORMALISE_EXC_EN
      out_oflow  <= 1'b0;
      out_uflow  <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= s1_vld;
      if (s1_vld) begin
        out_idle   <= s1_idle;
        out_sout   <= n_sout;
        out_sum    <= n_sum;
        out_z      <= s1_z;
        out_opcode <= s1_opcode;
        out_tag    <= s1_tag;
`ifdef NORMALISE_EXC_EN
        out_oflow  <= n_oflow;
        out_uflow  <= n_uflow;
`endif
      end
    end
  end

`ifndef NORMALISE_EXC_EN
  assign out_oflow = 1'b0;
  assign out_uflow = 1'b0;
`endif

endmodule

// File: tb/tb_normalise_adder_pipe.sv
// Directed self-checking bench for normalise_adder_pipe at default widths.
module tb_normalise_adder_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, in_idle;
  logic [31:0] in_sout;
  logic [27:0] in_sum;
  logic [31:0] in_z;
  logic [3:0]  in_opcode;
  logic [7:0]  in_tag;
  logic        out_valid, out_ready, out_idle;
  logic [31:0] out_sout;
  logic [27:0] out_sum;
  logic [31:0] out_z;
  logic [3:0]  out_opcode;
  logic [7:0]  out_tag;
  logic        out_oflow, out_uflow;

  int tests = 0;
  int fails = 0;
  logic [7:0] next_tag = 8'h10;

  always #5 clock = ~clock;

  normalise_adder_pipe dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_idle(in_idle),
    .in_sout(in_sout), .in_sum(in_sum), .in_z(in_z),
    .in_opcode(in_opcode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_idle(out_idle),
    .out_sout(out_sout), .out_sum(out_sum), .out_z(out_z),
    .out_opcode(out_opcode), .out_tag(out_tag),
    .out_oflow(out_oflow), .out_uflow(out_uflow)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // One isolated beat with out_ready high: checks latency, result and sideband.
  task automatic single(input string nm, input logic idl, input logic [31:0] so,
                        input logic [27:0] su, input logic [31:0] e_sout,
                        input logic [27:0] e_sum, input logic e_of, input logic e_uf);
    int n;
    logic [31:0] z;
    logic [3:0]  opc;
    logic [7:0]  tg;
    z   = $urandom;
    opc = 4'($urandom_range(0, 11));
    tg  = next_tag;
    next_tag++;
    @(negedge clock);
    in_valid = 1'b1; in_idle = idl; in_sout = so; in_sum = su;
    in_z = z; in_opcode = opc; in_tag = tg;
    @(negedge clock);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clock);
      n++;
    end
    check({nm, "_latency"}, 64'(n), 64'd2);
    check({nm, "_sout"}, 64'(out_sout), 64'(e_sout));
    check({nm, "_sum"}, 64'(out_sum), 64'(e_sum));
    check({nm, "_flags"}, {62'd0, out_oflow, out_uflow}, {62'd0, e_of, e_uf});
    check({nm, "_side"}, {19'd0, out_idle, out_z, out_opcode, out_tag},
          {19'd0, idl, z, opc, tg});
  endtask

  initial begin
    int sent, got, stalls;
    logic seen;
    reset = 1'b1; in_valid = 1'b0; in_idle = 1'b0; in_sout = '0; in_sum = '0;
    in_z = '0; in_opcode = '0; in_tag = '0; out_ready = 1'b1;
    #1;
    check("rst_valid", 64'(out_valid), 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_outs", {out_valid, out_sout, out_sum}, 64'd0);

    single("carry",   1'b0, 32'h3F800000, 28'h8000001, 32'h40000000, 28'h4000001, 1'b0, 1'b0);
    single("maxshift", 1'b0, 32'h3F800000, 28'h0000008, 32'h34000000, 28'h4000000, 1'b0, 1'b0);
    single("shift2",  1'b0, 32'h3F800000, 28'h1000000, 32'h3E800000, 28'h4000000, 1'b0, 1'b0);
    single("noshift", 1'b0, 32'h3F800000, 28'h4000000, 32'h3F800000, 28'h4000000, 1'b0, 1'b0);
    single("zero",    1'b0, 32'hBF812345, 28'h0000007, 32'h80012345, 28'h0000000, 1'b0, 1'b0);
    single("idle",    1'b1, 32'h12345678, 28'h8000001, 32'h12345678, 28'h0000000, 1'b0, 1'b0);
`ifdef NORMALISE_EXC_EN
    single("uflow",   1'b0, 32'h82800000, 28'h0000008, 32'h80000000, 28'h0000000, 1'b0, 1'b1);
    single("oflow",   1'b0, 32'h7F000000, 28'h8000000, 32'h7F800000, 28'h0000000, 1'b1, 1'b0);
`else
    single("uwrap",   1'b0, 32'h82800000, 28'h0000008, 32'hF7000000, 28'h4000000, 1'b0, 1'b0);
    single("owrap",   1'b0, 32'h7F000000, 28'h8000000, 32'h7F800000, 28'h4000000, 1'b0, 1'b0);
`endif

    // Back-pressure: tags 1..6 offered back-to-back, out_ready low in cycles 3..5.
    sent = 0; got = 0; stalls = 0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clock);
      out_ready = !(c >= 3 && c <= 5);
      in_valid  = (sent < 6);
      in_idle   = 1'b0;
      in_tag    = 8'(sent + 1);
      in_sout   = {1'b0, 8'd100, 23'(sent + 1)};
      in_sum    = 28'h4000000;
      in_z      = 32'(3 * (sent + 1));
      in_opcode = 4'(sent + 1);
      #1;
      if (c >= 3 && c <= 5) begin
        check("bp_hold_valid", 64'(out_valid), 64'd1);
        check("bp_hold_tag", 64'(out_tag), 64'd2);
        check("bp_in_ready", 64'(in_ready), 64'd0);
      end
      if (in_valid && !in_ready) stalls++;
      if (in_valid && in_ready) sent++;
      if (out_valid && out_ready) begin
        got++;
        check("bp_tag", 64'(out_tag), 64'(got));
        check("bp_data", {out_sout, out_z},
              {1'b0, 8'd100, 23'(got), 32'(3 * got)});
        check("bp_sum_opc", {out_sum, out_opcode}, {28'h4000000, 4'(got)});
      end
    end
    check("bp_count", 64'(got), 64'd6);
    check("bp_stalls", 64'(stalls), 64'd3);

    // Reset with both stages full.
    @(negedge clock);
    out_ready = 1'b0; in_valid = 1'b1; in_sout = 32'h3F800000; in_sum = 28'h4000000;
    in_tag = 8'h55; in_z = 32'hDEADBEEF;
    @(negedge clock);
    in_tag = 8'h66;
    @(negedge clock);
    in_valid = 1'b0;
    #1;
    check("full_valid", 64'(out_valid), 64'd1);
    check("full_tag", 64'(out_tag), 64'h55);
    check("full_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data", {out_sout, out_sum[27:0], out_tag}, 64'd0);
    check("mid_rst_z", 64'(out_z), 64'd0);
    @(negedge clock);
    reset = 1'b0; out_ready = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clock);
      seen = seen | out_valid;
    end
    check("no_stale", 64'(seen), 64'd0);
    check("post_rst_ready", 64'(in_ready), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
